// File: rtl/load_store_unit.sv
// Multi-cycle load/store engine: ALU effective address + rs2 store data driven
// onto a valid/grant/rvalid data-memory handshake, extended load data to writeback.
//
//   state | meaning
//   IDLE  | waiting for start; a legal access is latched here
//   REQ   | mem_req high, command held stable until mem_gnt
//   WAIT  | load granted, waiting for mem_rvalid
//   DONE  | one-cycle done pulse (with fault if the access failed)
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [31:0] rdata_out,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);

   state_t      state, state_nxt;
   logic        lat_load;
   logic [2:0]  lat_f3;
   logic [31:0] lat_addr, lat_wdata;
   logic        fault_q, fault_nxt;
   logic        accept, bad, tmo_hit, capture;
   logic [31:0] tmo_cnt, rdata_q, load_ext;
   logic [15:0] rshift;
   logic [3:0]  wstrb_lane;
   logic [31:0] wdata_lane;

   assign accept = start && (is_load ^ is_store);

   // Illegal width codes and misalignment both fault straight from IDLE
   always_comb begin
      bad = 1'b0;
      if (is_load) bad = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      else         bad = (funct3 > 3'd2);
      if ((funct3[1:0] == 2'd1) && addr[0])              bad = 1'b1;
      if ((funct3[1:0] == 2'd2) && (addr[1:0] != 2'b00)) bad = 1'b1;
   end

   // >= so a late grant that pushes a load past the limit still times out in WAIT
   assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt >= TMO);

   always_comb begin
      state_nxt = state;
      fault_nxt = fault_q;
      capture   = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = bad ? S_DONE : S_REQ;
               fault_nxt = bad;
            end
         end
         S_REQ: begin
            if (mem_gnt) begin
               state_nxt = lat_load ? S_WAIT : S_DONE;
            end else if (tmo_hit) begin
               state_nxt = S_DONE;
               fault_nxt = 1'b1;
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               state_nxt = S_DONE;
               capture   = 1'b1;
            end else if (tmo_hit) begin
               state_nxt = S_DONE;
               fault_nxt = 1'b1;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         fault_q   <= 1'b0;
         lat_load  <= 1'b0;
         lat_f3    <= 3'd0;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
         tmo_cnt   <= 32'd0;
         rdata_q   <= 32'd0;
      end else begin
         state   <= state_nxt;
         fault_q <= fault_nxt;
         if ((state == S_IDLE) && accept) begin
            lat_load  <= is_load;
            lat_f3    <= funct3;
            lat_addr  <= addr;
            lat_wdata <= wdata;
         end
         if ((state == S_IDLE) && (state_nxt == S_REQ)) tmo_cnt <= 32'd0;
         else if ((state == S_REQ) || (state == S_WAIT)) tmo_cnt <= tmo_cnt + 32'd1;
         if (capture) rdata_q <= load_ext;
      end
   end

   // Aligned halfwords sit at byte offset 0 or 2, so one byte-granular shift serves both
   assign rshift = 16'(mem_rdata >> {lat_addr[1:0], 3'b000});

   always_comb begin
      case (lat_f3)
         3'd0:    load_ext = {{24{rshift[7]}}, rshift[7:0]};
         3'd1:    load_ext = {{16{rshift[15]}}, rshift};
         3'd4:    load_ext = {24'd0, rshift[7:0]};
         3'd5:    load_ext = {16'd0, rshift};
         default: load_ext = mem_rdata;
      endcase
   end

   always_comb begin
      wstrb_lane = 4'b1111;
      wdata_lane = lat_wdata;
      case (lat_f3[1:0])
         2'd0: begin
            wstrb_lane = 4'b0001 << lat_addr[1:0];
            wdata_lane = {4{lat_wdata[7:0]}};
         end
         2'd1: begin
            wstrb_lane = 4'b0011 << lat_addr[1:0];
            wdata_lane = {2{lat_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign fault     = (state == S_DONE) && fault_q;
   assign rdata_out = rdata_q;
   assign mem_req   = (state == S_REQ);
   assign mem_we    = mem_req && !lat_load;
   assign mem_addr  = mem_req ? {lat_addr[31:2], 2'b00} : 32'd0;
   assign mem_wstrb = mem_we ? wstrb_lane : 4'b0000;
   assign mem_wdata = mem_we ? wdata_lane : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand sequences for reset and
// ignored starts, then random accesses against a transaction-level reference model.
module tb_load_store_unit;

   localparam int TMO = 4;

   logic        clk, rst_n, start, is_load, is_store;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        busy, done, fault;
   logic [31:0] rdata_out;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;

   load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load), .is_store(is_store),
      .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
      .fault(fault), .rdata_out(rdata_out), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_rdata;

   logic        m_fault;
   logic [3:0]  m_wstrb;
   logic [31:0] m_wdata;
   int          m_lat;

   typedef struct {
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] w;
      logic [31:0] md;
      int          d;
      int          r;
      logic        xf;
      logic [3:0]  xs;
      logic [31:0] xw;
      logic [31:0] xr;
      int          xl;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Reference: access outcome from the rules, walking elapsed REQ/WAIT cycles
   task automatic model(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] w, input logic [31:0] md, input int d, input int r);
      logic        bad;
      logic [31:0] lane;
      logic        fin;
      bad = ld ? (f3 == 3 || f3 == 6 || f3 == 7) : (f3 > 2);
      if (f3[1:0] == 2'd1 && a[0]) bad = 1'b1;
      if (f3[1:0] == 2'd2 && a[1:0] != 2'b00) bad = 1'b1;
      m_wstrb = 4'h0;
      m_wdata = 32'h0;
      if (!ld) begin
         case (f3[1:0])
            2'd0:    begin m_wstrb = 4'b0001 << a[1:0]; m_wdata = {4{w[7:0]}}; end
            2'd1:    begin m_wstrb = 4'b0011 << a[1:0]; m_wdata = {2{w[15:0]}}; end
            default: begin m_wstrb = 4'b1111; m_wdata = w; end
         endcase
      end
      m_fault = 1'b1;
      m_lat   = 1;
      if (!bad) begin
         fin = 1'b0;
         for (int i = 0; i < 64 && !fin; i++) begin
            if (ld ? (i == d + 1 + r) : (i == d)) begin
               fin = 1'b1;
               m_fault = 1'b0;
               m_lat = i + 2;
               if (ld) begin
                  lane = md >> (8 * a[1:0]);
                  case (f3)
                     3'd0:    exp_rdata = {{24{lane[7]}}, lane[7:0]};
                     3'd4:    exp_rdata = {24'd0, lane[7:0]};
                     3'd1:    exp_rdata = {{16{lane[15]}}, lane[15:0]};
                     3'd5:    exp_rdata = {16'd0, lane[15:0]};
                     default: exp_rdata = md;
                  endcase
               end
            end else if (i >= TMO && i != d) begin
               fin = 1'b1;
               m_fault = 1'b1;
               m_lat = i + 2;
            end
         end
      end
   endtask

   // Starts at a sample point; returns at the sample point of the done cycle
   task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] w, input logic [31:0] md,
                             input int d, input int r, input logic xf, input logic [3:0] xs,
                             input logic [31:0] xw, input logic [31:0] xr, input int xl);
      int   req_k, wait_k, xreq;
      logic in_wait, gnt_prev, seen_done;
      start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = w;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      req_k = 0; wait_k = 0; in_wait = 1'b0; seen_done = 1'b0;
      xreq = (xl == 1) ? 0 : (((d < TMO) ? d : TMO) + 1);
      for (int cyc = 1; cyc <= 30 && !seen_done; cyc++) begin
         @(posedge clk); #1;
         start = 1'b0; funct3 = 3'($urandom_range(0, 7)); addr = $urandom; wdata = $urandom;
         gnt_prev = mem_gnt;
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
         if (gnt_prev && ld) in_wait = 1'b1;
         if (in_wait) begin
            if (wait_k == r) begin mem_rvalid = 1'b1; mem_rdata = md; end
            wait_k++;
         end
         if (mem_req) begin
            chk("req_addr", mem_addr, {a[31:2], 2'b00});
            chk("req_we", mem_we, st);
            chk("req_wstrb", mem_wstrb, ld ? 4'h0 : xs);
            if (st) chk("req_wdata", mem_wdata, xw);
            if (req_k == d) mem_gnt = 1'b1;
            else mem_rvalid = 1'($urandom_range(0, 1));
            req_k++;
         end
         if (done) begin
            seen_done = 1'b1;
            chk("latency", cyc, xl);
            chk("fault", fault, xf);
            chk("rdata_out", rdata_out, xr);
         end
         chk("busy", busy, 1);
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!seen_done) begin
         errors++;
         $display("FAIL done_timeout actual=no_done required=done_by_cycle_%0d", xl);
      end
      chk("req_cycles", req_k, xreq);
   endtask

   task automatic idle_after;
      @(posedge clk); #1;
      chk("done_pulse", done, 0);
      chk("idle_busy", busy, 0);
   endtask

   logic        rl, rs;
   logic [2:0]  rf;
   logic [31:0] ra, rw, rm;
   int          rd, rr;

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0, 2};
      tbl[1]  = '{1'b0, 1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0, 0, 1'b0, 4'h8, 32'hA5A5A5A5, 32'h0, 2};
      tbl[2]  = '{1'b1, 1'b0, 3'd0, 32'h202, 32'h0, 32'h12F03456, 0, 0, 1'b0, 4'h0, 32'h0, 32'hFFFFFFF0, 3};
      tbl[3]  = '{1'b1, 1'b0, 3'd4, 32'h202, 32'h0, 32'h12F03456, 0, 0, 1'b0, 4'h0, 32'h0, 32'h000000F0, 3};
      tbl[4]  = '{1'b1, 1'b0, 3'd1, 32'h201, 32'h0, 32'h0, 0, 0, 1'b1, 4'h0, 32'h0, 32'h000000F0, 1};
      tbl[5]  = '{1'b1, 1'b0, 3'd2, 32'h300, 32'h0, 32'hCAFEF00D, 3, 0, 1'b0, 4'h0, 32'h0, 32'hCAFEF00D, 6};
      tbl[6]  = '{1'b1, 1'b0, 3'd2, 32'h304, 32'h0, 32'h11111111, 0, 99, 1'b1, 4'h0, 32'h0, 32'hCAFEF00D, 6};
      tbl[7]  = '{1'b0, 1'b1, 3'd1, 32'h102, 32'h1234BEEF, 32'h0, 0, 0, 1'b0, 4'hC, 32'hBEEFBEEF, 32'hCAFEF00D, 2};
      tbl[8]  = '{1'b1, 1'b0, 3'd1, 32'h206, 32'h0, 32'h80017FFF, 0, 0, 1'b0, 4'h0, 32'h0, 32'hFFFF8001, 3};
      tbl[9]  = '{1'b1, 1'b0, 3'd5, 32'h206, 32'h0, 32'h80017FFF, 0, 0, 1'b0, 4'h0, 32'h0, 32'h00008001, 3};
      tbl[10] = '{1'b0, 1'b1, 3'd3, 32'h100, 32'h0, 32'h0, 0, 0, 1'b1, 4'h0, 32'h0, 32'h00008001, 1};
      tbl[11] = '{1'b1, 1'b0, 3'd6, 32'h100, 32'h0, 32'h0, 0, 0, 1'b1, 4'h0, 32'h0, 32'h00008001, 1};
      tbl[12] = '{1'b0, 1'b1, 3'd2, 32'h101, 32'h0, 32'h0, 0, 0, 1'b1, 4'h0, 32'h0, 32'h00008001, 1};
      tbl[13] = '{1'b0, 1'b1, 3'd2, 32'h108, 32'h11223344, 32'h0, 5, 0, 1'b1, 4'hF, 32'h11223344, 32'h00008001, 6};
      tbl[14] = '{1'b1, 1'b0, 3'd5, 32'h202, 32'h0, 32'hABCD0000, 1, 1, 1'b0, 4'h0, 32'h0, 32'h0000ABCD, 5};

      rst_n = 1'b0; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
      addr = 32'h0; wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_fault", fault, 0);
      chk("rst_rdata", rdata_out, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wstrb", mem_wstrb, 0);
      chk("rst_wdata", mem_wdata, 0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      exp_rdata = 32'h0;

      for (int i = 0; i < 15; i++) begin
         run_access(tbl[i].ld, tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].w, tbl[i].md,
                    tbl[i].d, tbl[i].r, tbl[i].xf, tbl[i].xs, tbl[i].xw, tbl[i].xr, tbl[i].xl);
         idle_after();
      end
      exp_rdata = 32'h0000ABCD;

      // start while in DONE must not launch an access
      run_access(1'b0, 1'b1, 3'd2, 32'h140, 32'h5, 32'h0, 0, 0, 1'b0, 4'hF, 32'h5, exp_rdata, 2);
      start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h500;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_in_done", busy, 0);
      @(posedge clk); #1;
      chk("start_in_done_2", busy, 0);

      // both or neither access type: ignored
      start = 1'b1; is_load = 1'b1; is_store = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("both_types", busy, 0);
      start = 1'b1; is_load = 1'b0; is_store = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("no_type", busy, 0);

      // rvalid outside WAIT is ignored
      mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A;
      repeat (2) begin @(posedge clk); #1; end
      mem_rvalid = 1'b0;
      chk("rvalid_idle", rdata_out, exp_rdata);

      for (int n = 0; n < 150; n++) begin
         rl = 1'($urandom_range(0, 1));
         rs = !rl;
         rf = 3'($urandom_range(0, 7));
         ra = $urandom;
         if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
         rw = $urandom;
         rm = $urandom;
         rd = $urandom_range(0, 6);
         rr = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(0, 3);
         model(rl, rf, ra, rw, rm, rd, rr);
         run_access(rl, rs, rf, ra, rw, rm, rd, rr, m_fault, m_wstrb, m_wdata, exp_rdata, m_lat);
         idle_after();
      end

      // reset while in REQ: mem_req drops without a clock edge
      start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h400;
      @(posedge clk); #1;
      start = 1'b0;
      chk("rst_req_pre", mem_req, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_req_drop", mem_req, 0);
      chk("rst_req_busy", busy, 0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // reset while in WAIT: abort, no done, rdata cleared
      start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h404;
      @(posedge clk); #1;
      start = 1'b0; mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      chk("wait_busy", busy, 1);
      chk("wait_req", mem_req, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_wait_busy", busy, 0);
      chk("rst_wait_done", done, 0);
      chk("rst_wait_rdata", rdata_out, 0);
      exp_rdata = 32'h0;
      @(posedge clk); #1;
      #2 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("post_rst_done", done, 0);
         chk("post_rst_busy", busy, 0);
      end
      model(1'b1, 3'd2, 32'h600, 32'h0, 32'h89ABCDEF, 1, 0);
      run_access(1'b1, 1'b0, 3'd2, 32'h600, 32'h0, 32'h89ABCDEF, 1, 0,
                 m_fault, m_wstrb, m_wdata, exp_rdata, m_lat);
      idle_after();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
